// File: rtl/axi_w_arb_pkg.sv
// Shared types and helpers for the AXI W-channel order arbiter.
package axi_w_arb_pkg;

    // Arbiter FSM states: waiting for an order token, or forwarding a burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/axi_w_order_fifo.sv
// Order FIFO holding requester indices in AW-issue order; exposes the head
// and the entry behind it so back-to-back bursts can switch without a bubble.
module axi_w_order_fifo
    import axi_w_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 2,
    localparam int unsigned PTR_W = idx_width(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] head_next
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head      = mem[rd_ptr];
    assign head_next = mem[ptr_inc(rd_ptr)];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_w_order_arbiter.sv
// Routes W bursts from NUM_REQ requesters to one W stream in the order their
// AW requests were issued. Payload is muxed combinationally from the granted
// requester; only the grant, FSM state, beat counter and order FIFO hold state.
module axi_w_order_arbiter
    import axi_w_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned USER_WIDTH  = 1,
    parameter int unsigned ORDER_DEPTH = 4,
    parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned IDX_W       = idx_width(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            ord_valid_i,
    input  logic [IDX_W-1:0]                ord_idx_i,
    output logic                            ord_ready_o,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]   req_strb_i,
    input  logic [NUM_REQ*USER_WIDTH-1:0]   req_user_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            mst_valid_o,
    output logic [DATA_WIDTH-1:0]           mst_data_o,
    output logic [STRB_WIDTH-1:0]           mst_strb_o,
    output logic [USER_WIDTH-1:0]           mst_user_o,
    output logic                            mst_last_o,
    input  logic                            mst_ready_i,
    output logic                            busy_o,
    output logic [7:0]                      beat_cnt_o
);

    localparam int unsigned CNT_W = $clog2(ORDER_DEPTH + 1);

    state_t           state_q;
    logic [IDX_W-1:0] gnt_q;
    logic [7:0]       beat_cnt_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [IDX_W-1:0] fifo_head;
    logic [IDX_W-1:0] fifo_head_next;
    logic [IDX_W-1:0] ord_idx_safe;
    logic             ord_push;
    logic             beat;
    logic             last_beat;

    // Out-of-range indices are folded to requester 0 before queuing.
    assign ord_idx_safe = (32'(ord_idx_i) < NUM_REQ) ? ord_idx_i : '0;
    assign ord_ready_o  = ~fifo_full;
    assign ord_push     = ord_valid_i & ~fifo_full;
    assign beat         = mst_valid_o & mst_ready_i;
    assign last_beat    = beat & mst_last_o;
    assign busy_o       = (state_q == BURST);
    assign beat_cnt_o   = beat_cnt_q;

    axi_w_order_fifo #(
        .DEPTH  (ORDER_DEPTH),
        .DATA_W (IDX_W)
    ) u_order_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (ord_push),
        .pop       (last_beat),
        .din       (ord_idx_safe),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head),
        .head_next (fifo_head_next)
    );

    // Payload mux and handshake steering from the granted requester only.
    always_comb begin
        mst_valid_o = 1'b0;
        mst_data_o  = '0;
        mst_strb_o  = '0;
        mst_user_o  = '0;
        mst_last_o  = 1'b0;
        req_ready_o = '0;
        if (state_q == BURST) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (gnt_q == IDX_W'(k)) begin
                    mst_valid_o    = req_valid_i[k];
                    mst_data_o     = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    mst_strb_o     = req_strb_i[k*STRB_WIDTH +: STRB_WIDTH];
                    mst_user_o     = req_user_i[k*USER_WIDTH +: USER_WIDTH];
                    mst_last_o     = req_last_i[k];
                    req_ready_o[k] = mst_ready_i;
                end
            end
        end
    end

    // Grant FSM: IDLE loads the FIFO head (one bubble); a last beat either
    // chains straight into the next queued burst or returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (!fifo_empty) begin
                        gnt_q   <= fifo_head;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        beat_cnt_q <= '0;
                        if (fifo_count > CNT_W'(1)) begin
                            gnt_q <= fifo_head_next;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (beat && beat_cnt_q != 8'hFF) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_w_order_arbiter.sv
// Directed, self-checking bench for axi_w_order_arbiter (4 requesters, 64-bit data).
module tb_axi_w_order_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 8;
    localparam int unsigned UW = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ord_valid;
    logic [1:0]        ord_idx;
    logic              ord_ready;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR*SW-1:0]  req_strb;
    logic [NR*UW-1:0]  req_user;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              mst_valid;
    logic [DW-1:0]     mst_data;
    logic [SW-1:0]     mst_strb;
    logic [UW-1:0]     mst_user;
    logic              mst_last;
    logic              mst_ready;
    logic              busy;
    logic [7:0]        beat_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_w_order_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .USER_WIDTH  (UW),
        .ORDER_DEPTH (4),
        .STRB_WIDTH  (SW),
        .IDX_W       (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ord_valid_i (ord_valid),
        .ord_idx_i   (ord_idx),
        .ord_ready_o (ord_ready),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_strb_i  (req_strb),
        .req_user_i  (req_user),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .mst_valid_o (mst_valid),
        .mst_data_o  (mst_data),
        .mst_strb_o  (mst_strb),
        .mst_user_o  (mst_user),
        .mst_last_o  (mst_last),
        .mst_ready_i (mst_ready),
        .busy_o      (busy),
        .beat_cnt_o  (beat_cnt)
    );

    typedef struct packed {
        logic [3:0] valid;
        logic       ready;
        logic [3:0] last;
        logic       e_valid;
        logic [3:0] e_rdy;
        logic       e_last;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [63:0] pat_data(input int k);
        return {32'hCAFE_0000 + 32'(k), 32'h0BAD_F00D ^ 32'(k * 7)};
    endfunction

    function automatic logic [7:0] pat_strb(input int k);
        return {4'(k + 1), 4'hA};
    endfunction

    function automatic logic pat_user(input int k);
        return 1'(k);
    endfunction

    function automatic int idx_of(input logic [3:0] r);
        case (r)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 9;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] idx);
        @(negedge clk);
        ord_valid = 1'b1;
        ord_idx   = idx;
        @(negedge clk);
        ord_valid = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 10 && !busy; i++) begin
            @(negedge clk);
            #1;
        end
        check(name, 64'(busy), 64'(1));
    endtask

    // Collects up to four handshaked beats, recording grant order and the
    // cycle span from first to fourth beat; two_beat ends each burst on beat 2.
    task automatic collect(input bit two_beat, output int got[4], output int n, output int span);
        int sent[4];
        int first_c;
        int g;
        sent    = '{0, 0, 0, 0};
        got     = '{9, 9, 9, 9};
        n       = 0;
        span    = 0;
        first_c = 0;
        for (int c = 0; c < 24 && n < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                req_last[k] = two_beat ? (sent[k] == 1) : 1'b1;
            end
            #1;
            if (mst_valid && mst_ready) begin
                g = idx_of(req_ready);
                if (n == 0) first_c = c;
                got[n] = g;
                n++;
                span = c - first_c;
                check("beat_data", mst_data, pat_data(g));
                if (g < 4) sent[g]++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int got[4];
        int n;
        int span;
        logic rs[4];
        int   ec[4];

        for (int k = 0; k < 4; k++) begin
            req_data[k*DW +: DW] = pat_data(k);
            req_strb[k*SW +: SW] = pat_strb(k);
            req_user[k*UW +: UW] = pat_user(k);
        end
        rst = 1'b1; ord_valid = 1'b0; ord_idx = '0;
        req_valid = '0; req_last = '0; mst_ready = 1'b0;

        tbl[0] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'd0};
        tbl[1] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd1};
        tbl[2] = '{4'b1011, 1'b1, 4'b1011, 1'b0, 4'b0100, 1'b0, 8'd1};
        tbl[3] = '{4'b0100, 1'b1, 4'b0010, 1'b1, 4'b0100, 1'b0, 8'd1};
        tbl[4] = '{4'b1111, 1'b1, 4'b1011, 1'b1, 4'b0100, 1'b0, 8'd2};
        tbl[5] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd3};
        tbl[6] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd3};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ord_ready", 64'(ord_ready), 64'(1));
        check("rst_mst_valid", 64'(mst_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        check("rst_mst_data", mst_data, 64'(0));

        // Single 4-beat burst on requester 2
        req_valid = 4'b0100; mst_ready = 1'b1;
        push(2'd2);
        #1;
        check("s1_bubble_busy", 64'(busy), 64'(0));
        check("s1_bubble_valid", 64'(mst_valid), 64'(0));
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            req_last = (b == 3) ? 4'b0100 : 4'b0000;
            #1;
            check("s1_busy", 64'(busy), 64'(1));
            check("s1_valid", 64'(mst_valid), 64'(1));
            check("s1_cnt", 64'(beat_cnt), 64'(b));
            check("s1_rdy", 64'(req_ready), 64'(4'b0100));
            check("s1_last", 64'(mst_last), 64'(b == 3));
            check("s1_data", mst_data, pat_data(2));
        end
        @(negedge clk);
        req_last = '0; req_valid = '0;
        #1;
        check("s1_idle_busy", 64'(busy), 64'(0));
        check("s1_idle_cnt", 64'(beat_cnt), 64'(0));

        // Routing table during a burst on requester 2
        push(2'd2);
        wait_busy("tbl_wait_busy");
        for (int i = 0; i < 7; i++) begin
            req_valid = tbl[i].valid;
            mst_ready = tbl[i].ready;
            req_last  = tbl[i].last;
            #1;
            check($sformatf("tbl%0d_valid", i), 64'(mst_valid), 64'(tbl[i].e_valid));
            check($sformatf("tbl%0d_rdy", i), 64'(req_ready), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_last", i), 64'(mst_last), 64'(tbl[i].e_last));
            check($sformatf("tbl%0d_cnt", i), 64'(beat_cnt), 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_data", i), mst_data, pat_data(2));
            check($sformatf("tbl%0d_strb", i), 64'(mst_strb), 64'(pat_strb(2)));
            check($sformatf("tbl%0d_user", i), 64'(mst_user), 64'(pat_user(2)));
            @(negedge clk);
        end
        req_valid = 4'b1111; req_last = 4'b1111; mst_ready = 1'b1;
        #1;
        check("tbl_idle_busy", 64'(busy), 64'(0));
        check("tbl_idle_valid", 64'(mst_valid), 64'(0));
        check("tbl_idle_rdy", 64'(req_ready), 64'(0));
        check("tbl_idle_data", mst_data, 64'(0));
        check("tbl_idle_strb", 64'(mst_strb), 64'(0));
        check("tbl_idle_last", 64'(mst_last), 64'(0));

        // Two queued bursts run back to back in order
        req_valid = '0; req_last = '0;
        push(2'd1);
        push(2'd3);
        req_valid = 4'b1010;
        collect(1'b1, got, n, span);
        check("s2_nbeats", 64'(n), 64'(4));
        check("s2_g0", 64'(got[0]), 64'(1));
        check("s2_g1", 64'(got[1]), 64'(1));
        check("s2_g2", 64'(got[2]), 64'(3));
        check("s2_g3", 64'(got[3]), 64'(3));
        check("s2_span", 64'(span), 64'(3));
        req_valid = '0; req_last = '0;
        #1;
        check("s2_idle", 64'(busy), 64'(0));

        // Full FIFO holds off a fifth token until the first pop
        @(negedge clk);
        ord_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t > 0) @(negedge clk);
            ord_idx = 2'(t);
            #1;
            check($sformatf("s3_ready_push%0d", t), 64'(ord_ready), 64'(1));
        end
        @(negedge clk);
        ord_idx = 2'd1;
        #1;
        check("s3_full", 64'(ord_ready), 64'(0));
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            #1;
            check("s3_full_hold", 64'(ord_ready), 64'(0));
        end
        @(negedge clk);
        req_valid = 4'b0001; req_last = 4'b0001; mst_ready = 1'b1;
        #1;
        check("s3_full_at_last", 64'(ord_ready), 64'(0));
        check("s3_rdy0", 64'(req_ready), 64'(4'b0001));
        @(negedge clk);
        req_valid = '0;
        #1;
        check("s3_ready_after_pop", 64'(ord_ready), 64'(1));
        check("s3_still_busy", 64'(busy), 64'(1));
        check("s3_cnt_clear", 64'(beat_cnt), 64'(0));
        @(negedge clk);
        ord_valid = 1'b0;
        req_valid = 4'b1111;
        collect(1'b0, got, n, span);
        check("s3_nbeats", 64'(n), 64'(4));
        check("s3_g0", 64'(got[0]), 64'(1));
        check("s3_g1", 64'(got[1]), 64'(2));
        check("s3_g2", 64'(got[2]), 64'(3));
        check("s3_g3", 64'(got[3]), 64'(1));
        check("s3_span", 64'(span), 64'(3));
        req_valid = '0; req_last = '0;
        #1;
        check("s3_idle", 64'(busy), 64'(0));

        // Backpressure on requester 0 with requester 1 also valid
        mst_ready = 1'b0;
        req_valid = 4'b0011;
        push(2'd0);
        wait_busy("s4_wait_busy");
        rs = '{1'b1, 1'b0, 1'b1, 1'b0};
        ec = '{0, 1, 1, 2};
        for (int i = 0; i < 4; i++) begin
            mst_ready = rs[i];
            #1;
            check($sformatf("s4_rdy%0d", i), 64'(req_ready), 64'({3'b000, rs[i]}));
            check($sformatf("s4_cnt%0d", i), 64'(beat_cnt), 64'(ec[i]));
            @(negedge clk);
        end
        #1;
        check("s4_cnt_end", 64'(beat_cnt), 64'(2));
        req_last = 4'b0001; mst_ready = 1'b1;
        @(negedge clk);
        req_valid = '0; req_last = '0;
        #1;
        check("s4_idle", 64'(busy), 64'(0));

        // Reset mid-burst discards queued tokens
        mst_ready = 1'b1;
        push(2'd3);
        push(2'd1);
        push(2'd2);
        req_valid = 4'b1000;
        #1;
        check("s5_beat1_cnt", 64'(beat_cnt), 64'(0));
        check("s5_beat1_busy", 64'(busy), 64'(1));
        @(negedge clk);
        #1;
        check("s5_beat2_cnt", 64'(beat_cnt), 64'(1));
        check("s5_queue_cnt", 64'(ord_ready), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("s5_rst_busy", 64'(busy), 64'(0));
        check("s5_rst_ord_ready", 64'(ord_ready), 64'(1));
        check("s5_rst_valid", 64'(mst_valid), 64'(0));
        check("s5_rst_cnt", 64'(beat_cnt), 64'(0));
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("s5_no_grant%0d", i), 64'(busy), 64'(0));
            check($sformatf("s5_no_rdy%0d", i), 64'(req_ready), 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_w_order_arbiter.md
AXI_W_ORDER_ARBITER -- requirements
Module: axi_w_order_arbiter

Interface
REQ-001 Parameters SHALL be exactly these, one per line:
- NUM_REQ, default 4: number of W requesters.
- DATA_WIDTH, default 64: W data width.
- USER_WIDTH, default 1: W user width.
- ORDER_DEPTH, default 4: order-FIFO entries.
- STRB_WIDTH, default DATA_WIDTH/8: strobe width.
- IDX_W, default clog2(NUM_REQ) with minimum 1: index width.
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be exactly these (name, direction, width, meaning):
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous active-high reset.
- ord_valid_i, in, 1: AW-accept order token valid.
- ord_idx_i, in, IDX_W: requester index whose AW was issued.
- ord_ready_o, out, 1: order FIFO can accept.
- req_valid_i, in, NUM_REQ: per-requester W valid.
- req_data_i, in, NUM_REQ*DATA_WIDTH: flattened data; requester k occupies slice k.
- req_strb_i, in, NUM_REQ*STRB_WIDTH: flattened strobes.
- req_user_i, in, NUM_REQ*USER_WIDTH: flattened user.
- req_last_i, in, NUM_REQ: per-requester last.
- req_ready_o, out, NUM_REQ: per-requester ready.
- mst_valid_o, mst_data_o, mst_strb_o, mst_user_o, mst_last_o, out, 1/DATA_WIDTH/STRB_WIDTH/USER_WIDTH/1: W stream toward the W buffer.
- mst_ready_i, in, 1: W buffer ready.
- busy_o, out, 1: burst in progress.
- beat_cnt_o, out, 8: beats forwarded in the current burst.

Function
REQ-004 The order FIFO SHALL hold ORDER_DEPTH indices; ord_ready_o = not full; a push occurs on ord_valid_i & ord_ready_o.
REQ-005 A push while full SHALL NOT occur, even if a pop happens in the same cycle; ord_ready_o depends only on the registered count.
REQ-006 The FSM SHALL have states IDLE and BURST, plus a registered grant index gnt_q.
REQ-007 In IDLE with the FIFO non-empty, the FSM SHALL load gnt_q from the FIFO head and enter BURST next cycle, leaving one bubble cycle. A token pushed into an empty FIFO is visible the cycle after the push.
REQ-008 In BURST, the block SHALL set mst_valid_o = req_valid_i[gnt_q] and route data, strb, user and last from slice gnt_q.
REQ-009 req_ready_o[gnt_q] SHALL equal mst_ready_i; every other req_ready_o bit SHALL be 0. All req_ready_o bits SHALL be 0 in IDLE.
REQ-010 A beat is a BURST-state cycle with mst_valid_o & mst_ready_i.
REQ-011 beat_cnt_o SHALL increment per beat and saturate at 255.
REQ-012 On a beat with mst_last_o=1, the FIFO head SHALL be popped and beat_cnt_o cleared.
- If the FIFO holds at least 2 entries, gnt_q SHALL load the next entry and the FSM stays in BURST with no bubble.
- Otherwise the FSM SHALL go to IDLE. A push in that same cycle is taken via the REQ-007 path.
REQ-013 Push and pop in the same cycle SHALL leave the count unchanged; pointers wrap modulo ORDER_DEPTH.
REQ-014 In IDLE, mst_valid_o SHALL be 0 and the mst_* payload outputs SHALL be 0.
REQ-015 Valid from a non-granted requester SHALL be ignored. Payload SHALL NOT be reordered or modified.
REQ-016 busy_o SHALL be 1 exactly while in BURST.
REQ-017 ord_idx_i values >= NUM_REQ are illegal. If one is received, the block SHALL treat it as index 0; no error is flagged.

Reset
REQ-018 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, gnt_q=0, FIFO pointers and count=0, and beat_cnt_o=0.
REQ-019 After reset: ord_ready_o=1, mst_valid_o=0, req_ready_o=0, busy_o=0.
REQ-020 A reset mid-burst SHALL discard all queued tokens. The partial burst is abandoned, and upstream is responsible for it.

Structure
REQ-021 Package axi_w_arb_pkg SHALL hold the state enum {IDLE, BURST} and the index-width function.
REQ-022 The order FIFO SHALL be sub-module axi_w_order_fifo, parameterised by DEPTH and DATA_W. It has push/pop/full/empty/count/head ports and an active-high synchronous reset.
REQ-023 The W payload path SHALL contain no registers; the only state is the FSM, gnt_q, beat_cnt_o and the FIFO.

Verification
REQ-024 Push idx 2, then present 4 beats on req 2 with last on beat 4 and mst_ready_i=1. Required: one bubble cycle, then 4 consecutive beats; beat_cnt_o reads 0,1,2,3, then 0; IDLE next cycle.
REQ-025 Push idx 1 and then idx 3; each requester sends a 2-beat burst. Required: req1 beats, then req3 beats back-to-back with no bubble; req3 is never granted first.
REQ-026 Push 4 tokens, then assert ord_valid_i a fifth time. Required: ord_ready_o=0 and the fifth token is held. After the first last-beat it is accepted the following cycle.
REQ-027 Grant on req 0; req 1 valid held high; mst_ready_i toggles 1,0,1,0. Required: req_ready_o[1] stays 0, req_ready_o[0] mirrors mst_ready_i, and beat_cnt_o advances only on ready=1.
REQ-028 Assert rst_i for 1 cycle during beat 2 of a 4-beat burst with 2 tokens queued. Required: next cycle IDLE, ord_ready_o=1, mst_valid_o=0, beat_cnt_o=0, and no grant without a new push.
